bus_timer: RTL and testbench

- Memory-mapped timer that acts as a responder on the CPU memory bus.
- Answers the single-cycle mem_rd / mem_wr accesses issued by the control unit.
- Counts down at a programmable prescaled rate and raises the level-sensitive hwint line that the control unit samples in FETCH.
- Sits beside RAM on the shared address/data bus; decodes a 4-word window at BASE_ADDR.

---
 rtl/timer_pkg.sv | 27 ++
 rtl/bus_timer_prescaler.sv | 27 ++
 rtl/bus_timer.sv | 137 +++++++++++++
 tb/tb_bus_timer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types for the memory-mapped bus timer: register offsets, CTRL layout,
// and the size of the decoded window.
package timer_pkg;

  typedef enum logic [1:0] {
    CTRL   = 2'd0,
    LOAD   = 2'd1,
    COUNT  = 2'd2,
    STATUS = 2'd3
  } timer_reg_e;

  typedef struct packed {
    logic [7:0] prescale;
    logic [4:0] reserved;
    logic       irq_en;
    logic       auto_reload;
    logic       enable;
  } timer_ctrl_t;

  localparam int unsigned TIMER_WINDOW = 4;

  // CTRL as seen on the bus; reserved bits are held at zero by the writer.
  function automatic logic [31:0] ctrl_word(input timer_ctrl_t c);
    return {16'h0000, c};
  endfunction

endpackage

// File: rtl/bus_timer_prescaler.sv
// 8-bit compare-and-wrap prescaler: counts while enabled and emits a tick
// on the cycle its count equals the programmed prescale value.
module bus_timer_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_enable,
  input  logic       i_clear,
  input  logic [7:0] i_prescale,
  output logic       o_tick
);

  logic [7:0] r_pcnt;

  assign o_tick = i_enable && (r_pcnt == i_prescale);

  // The 8-bit increment wraps naturally if prescale is lowered below pcnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt <= 8'd0;
    end else if (i_clear || o_tick) begin
      r_pcnt <= 8'd0;
    end else if (i_enable) begin
      r_pcnt <= r_pcnt + 8'd1;
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped down-counting timer on the CPU bus: a 4-word register window,
// zero-latency reads, posted writes and a level interrupt to the control unit.
module bus_timer
  import timer_pkg::*;
#(
  parameter int unsigned          ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = 16'hFF00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_data_in,
  input  logic              i_mem_rd,
  input  logic              i_mem_wr,
  output logic [31:0]       o_data_out,
  output logic              o_data_oe,
  output logic              o_hwint
);

  timer_ctrl_t r_ctrl;
  logic [31:0] r_load;
  logic [31:0] r_count;
  logic        r_pending;

  timer_ctrl_t w_ctrl_nxt;
  logic [31:0] w_load_nxt;
  logic [31:0] w_count_nxt;
  logic        w_pending_nxt;

  logic        w_hit;
  timer_reg_e  w_off;
  logic        w_rd;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_load;
  logic        w_wr_count;
  logic        w_wr_status;
  logic        w_tick;
  logic        w_expire;
  logic        w_pcnt_clr;

  // Address decode
  assign w_hit = (i_addr[ADDR_W-1:2] == BASE_ADDR[ADDR_W-1:2]);
  assign w_off = timer_reg_e'(i_addr[1:0]);
  assign w_rd  = w_hit && i_mem_rd;
  assign w_wr  = w_hit && i_mem_wr;

  assign w_wr_ctrl   = w_wr && (w_off == CTRL);
  assign w_wr_load   = w_wr && (w_off == LOAD);
  assign w_wr_count  = w_wr && (w_off == COUNT);
  assign w_wr_status = w_wr && (w_off == STATUS);

  // Restart the prescale phase only on an enable rising edge written by software.
  assign w_pcnt_clr = w_wr_ctrl && i_data_in[0] && !r_ctrl.enable;

  bus_timer_prescaler u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .i_enable   (r_ctrl.enable),
    .i_clear    (w_pcnt_clr),
    .i_prescale (r_ctrl.prescale),
    .o_tick     (w_tick)
  );

  // A same-cycle COUNT write suppresses both decrement and expiry.
  assign w_expire = w_tick && (r_count == 32'd0) && !w_wr_count;

  always_comb begin
    w_ctrl_nxt    = r_ctrl;
    w_load_nxt    = r_load;
    w_count_nxt   = r_count;
    w_pending_nxt = r_pending;

    if (w_tick && !w_wr_count) begin
      if (r_count != 32'd0) begin
        w_count_nxt = r_count - 32'd1;
      end else if (r_ctrl.auto_reload) begin
        w_count_nxt = r_load;
      end else begin
        w_ctrl_nxt.enable = 1'b0;
      end
    end

    // Expiry beats a simultaneous write-1-to-clear.
    if (w_expire) begin
      w_pending_nxt = 1'b1;
    end else if (w_wr_status && i_data_in[0]) begin
      w_pending_nxt = 1'b0;
    end

    if (w_wr_ctrl) begin
      w_ctrl_nxt.prescale    = i_data_in[15:8];
      w_ctrl_nxt.reserved    = 5'd0;
      w_ctrl_nxt.irq_en      = i_data_in[2];
      w_ctrl_nxt.auto_reload = i_data_in[1];
      w_ctrl_nxt.enable      = i_data_in[0];
    end
    if (w_wr_load) begin
      w_load_nxt = i_data_in;
    end
    if (w_wr_count) begin
      w_count_nxt = i_data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl    <= '0;
      r_load    <= 32'd0;
      r_count   <= 32'd0;
      r_pending <= 1'b0;
    end else begin
      r_ctrl    <= w_ctrl_nxt;
      r_load    <= w_load_nxt;
      r_count   <= w_count_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  // Zero-latency read mux; the bus sees zero whenever this block is not selected.
  always_comb begin
    o_data_out = 32'd0;
    if (w_rd) begin
      case (w_off)
        CTRL:    o_data_out = ctrl_word(r_ctrl);
        LOAD:    o_data_out = r_load;
        COUNT:   o_data_out = r_count;
        STATUS:  o_data_out = {31'd0, r_pending};
        default: o_data_out = 32'd0;
      endcase
    end
  end

  assign o_data_oe = w_rd;
  assign o_hwint   = r_pending && r_ctrl.irq_en;

endmodule

// File: tb/tb_bus_timer.sv
// Directed and randomized bench for bus_timer against a cycle-level behavioural model.
module tb_bus_timer;

  localparam logic [15:0] BASE = 16'hFF00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [31:0] din = 32'h0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] dout;
  logic        oe;
  logic        hwint;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic        m_en, m_ar, m_irq, m_pend;
  logic [7:0]  m_ps, m_ph;
  logic [31:0] m_load, m_cnt;

  bus_timer #(
    .ADDR_W    (16),
    .BASE_ADDR (BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_addr     (addr),
    .i_data_in  (din),
    .i_mem_rd   (rd),
    .i_mem_wr   (wr),
    .o_data_out (dout),
    .o_data_oe  (oe),
    .o_hwint    (hwint)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    m_en = 0; m_ar = 0; m_irq = 0; m_pend = 0;
    m_ps = 0; m_ph = 0; m_load = 0; m_cnt = 0;
  endtask

  function automatic logic [31:0] mdl_read(input logic [1:0] off);
    case (off)
      2'd0:    return {16'h0, m_ps, 5'b0, m_irq, m_ar, m_en};
      2'd1:    return m_load;
      2'd2:    return m_cnt;
      default: return {31'b0, m_pend};
    endcase
  endfunction

  function automatic logic mdl_expiring();
    return m_en && (m_ph == m_ps) && (m_cnt == 0);
  endfunction

  // Advance the model by one clock given the bus access presented this cycle.
  task automatic mdl_step(input logic hit, input logic w, input logic [1:0] off,
                          input logic [31:0] d);
    logic tick, cw, expire;
    logic [31:0] cnt;
    logic en, pend;
    logic [7:0] ph;
    tick   = m_en && (m_ph == m_ps);
    cw     = hit && w && (off == 2'd2);
    expire = tick && (m_cnt == 0) && !cw;
    cnt = m_cnt; en = m_en; pend = m_pend; ph = m_ph;
    if (hit && w && off == 2'd0 && d[0] && !m_en) ph = 8'd0;
    else if (m_en) ph = tick ? 8'd0 : m_ph + 8'd1;
    if (tick && !cw) begin
      if (m_cnt != 0) cnt = m_cnt - 1;
      else if (m_ar) cnt = m_load;
      else en = 1'b0;
    end
    if (expire) pend = 1'b1;
    else if (hit && w && off == 2'd3 && d[0]) pend = 1'b0;
    if (hit && w) begin
      case (off)
        2'd0: begin en = d[0]; m_ar = d[1]; m_irq = d[2]; m_ps = d[15:8]; end
        2'd1: m_load = d;
        2'd2: cnt = d;
        default: ;
      endcase
    end
    m_cnt = cnt; m_en = en; m_pend = pend; m_ph = ph;
  endtask

  // One bus cycle: drive after negedge, check combinational outputs, step model, wait edge.
  task automatic cycle(input logic r, input logic w, input logic [15:0] a,
                       input logic [31:0] d, input string tag,
                       output logic [31:0] q, output logic qoe, output logic qhw);
    logic hit;
    @(negedge clk);
    addr = a; din = d; rd = r; wr = w;
    #1;
    hit = (a[15:2] == BASE[15:2]);
    q = dout; qoe = oe; qhw = hwint;
    chk({tag, "/oe"}, {31'b0, oe}, {31'b0, hit && r});
    chk({tag, "/data"}, dout, (hit && r) ? mdl_read(a[1:0]) : 32'h0);
    chk({tag, "/hwint"}, {31'b0, hwint}, {31'b0, m_pend && m_irq});
    mdl_step(hit, w, a[1:0], d);
    @(posedge clk);
  endtask

  logic [31:0] q;
  logic        qoe, qhw;
  logic        found;
  logic [31:0] exp_seq [9];

  task automatic wr_reg(input logic [1:0] off, input logic [31:0] d, input string tag);
    logic [31:0] tq; logic to, th;
    cycle(1'b0, 1'b1, BASE + {14'b0, off}, d, tag, tq, to, th);
  endtask

  task automatic rd_reg(input logic [1:0] off, input string tag,
                        output logic [31:0] rq, output logic rhw);
    logic ro;
    cycle(1'b1, 1'b0, BASE + {14'b0, off}, 32'h0, tag, rq, ro, rhw);
  endtask

  task automatic idle(input string tag);
    logic [31:0] tq; logic to, th;
    cycle(1'b0, 1'b0, 16'h0000, 32'h0, tag, tq, to, th);
  endtask

  initial begin
    mdl_reset();
    exp_seq = '{32'd3, 32'd3, 32'd2, 32'd2, 32'd1, 32'd1, 32'd0, 32'd0, 32'd3};
    repeat (2) @(negedge clk);
    #1;
    chk("rst_hwint", {31'b0, hwint}, 32'd0);
    chk("rst_oe", {31'b0, oe}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset readback and window miss
    for (int i = 0; i < 4; i++) begin
      rd_reg(2'(i), "rst_read", q, qhw);
      chk("rst_zero", q, 32'd0);
    end
    cycle(1'b1, 1'b0, BASE + 16'd4, 32'h0, "miss", q, qoe, qhw);
    chk("miss_oe", {31'b0, qoe}, 32'd0);

    // Auto-reload: period (3+1)*(1+1) = 8 cycles
    wr_reg(2'd1, 32'd3, "ar_load");
    wr_reg(2'd2, 32'd3, "ar_count");
    wr_reg(2'd0, 32'h0000_0107, "ar_ctrl");
    for (int i = 0; i < 9; i++) begin
      rd_reg(2'd2, "ar_read", q, qhw);
      chk("ar_seq", q, exp_seq[i]);
      if (i == 7) chk("ar_hw_lo", {31'b0, qhw}, 32'd0);
      if (i == 8) chk("ar_hw_hi", {31'b0, qhw}, 32'd1);
    end

    // Clear racing an expiry: set wins
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mdl_expiring()) begin
        found = 1'b1;
        break;
      end
      rd_reg(2'd2, "race_wait", q, qhw);
    end
    chk("race_find", {31'b0, found}, 32'd1);
    wr_reg(2'd3, 32'd1, "race_clr");
    rd_reg(2'd3, "race_stat", q, qhw);
    chk("race_pend", q, 32'd1);
    chk("race_hw", {31'b0, qhw}, 32'd1);
    wr_reg(2'd3, 32'd1, "clr");
    rd_reg(2'd3, "clr_stat", q, qhw);
    chk("clr_hw", {31'b0, qhw}, 32'd0);

    // One-shot with prescale 0
    wr_reg(2'd0, 32'd0, "os_off");
    wr_reg(2'd3, 32'd1, "os_clr");
    wr_reg(2'd2, 32'd2, "os_count");
    wr_reg(2'd0, 32'h0000_0005, "os_ctrl");
    repeat (3) idle("os_run");
    rd_reg(2'd3, "os_stat", q, qhw);
    chk("os_pend", q, 32'd1);
    rd_reg(2'd0, "os_ctrl_rd", q, qhw);
    chk("os_ctrl", q, 32'h0000_0004);
    rd_reg(2'd2, "os_cnt_rd", q, qhw);
    chk("os_cnt", q, 32'd0);
    wr_reg(2'd3, 32'd1, "os_clr2");
    repeat (20) idle("os_quiet");
    rd_reg(2'd3, "os_stat2", q, qhw);
    chk("os_no_rerun", q, 32'd0);

    // COUNT write on a tick cycle wins
    wr_reg(2'd0, 32'h0000_0001, "cw_ctrl");
    wr_reg(2'd2, 32'd5, "cw_5");
    wr_reg(2'd2, 32'd100, "cw_100");
    rd_reg(2'd2, "cw_read", q, qhw);
    chk("cw_wins", q, 32'd100);

    // Async reset while hwint is high
    wr_reg(2'd0, 32'd0, "ar2_off");
    wr_reg(2'd2, 32'd0, "ar2_cnt");
    wr_reg(2'd0, 32'h0000_0005, "ar2_ctrl");
    idle("ar2_exp");
    @(negedge clk);
    #1;
    chk("pre_rst_hw", {31'b0, hwint}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_hw", {31'b0, hwint}, 32'd0);
    mdl_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) idle("post_rst");
    rd_reg(2'd0, "post_ctrl", q, qhw);
    chk("post_rst_idle", q, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int unsigned op;
      logic [1:0]  off;
      logic [15:0] a;
      logic [31:0] d;
      op  = $urandom_range(0, 7);
      off = 2'($urandom_range(0, 3));
      a   = BASE + {14'b0, off};
      if ($urandom_range(0, 7) == 0) a = 16'($urandom);
      d = $urandom;
      if (off == 2'd0) d[15:8] = 8'($urandom_range(0, 3));
      else if (off != 2'd3) d = 32'($urandom_range(0, 6));
      if (op < 3)      cycle(1'b0, 1'b0, a, d, "rnd_idle", q, qoe, qhw);
      else if (op < 5) cycle(1'b1, 1'b0, a, d, "rnd_rd", q, qoe, qhw);
      else if (op < 7) cycle(1'b0, 1'b1, a, d, "rnd_wr", q, qoe, qhw);
      else             cycle(1'b1, 1'b1, a, d, "rnd_rdwr", q, qoe, qhw);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
